// File: rtl/hs_arith_stream_uminimize.sv
// hs_arith_stream_uminimize
//
// Unsigned minimum finder over a framed input stream. Beats are taken while
// the block is in ACCUM. The beat carrying s_last closes the frame, and the
// registered result is then held in HOLD until the downstream accepts it.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both 1. Valid is never withdrawn by this block
// before its transfer, and ready never depends combinationally on valid.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   s_data        unsigned input value (DATA_WIDTH)
//   s_aux         auxiliary payload travelling with each beat
//   s_valid       input beat valid
//   s_last        final beat of the frame
//   s_ready       1 while accumulating (ACCUM)
//   m_value       frame minimum
//   m_aux         auxiliary payload of the minimum beat ('0 if aux path off)
//   m_index       zero-based beat position of the minimum (saturating)
//   m_count       accepted beats minus 1 (saturating at 2^IDX_WIDTH-1)
//   m_overflow    frame had more than 2^IDX_WIDTH beats
//   m_valid       result valid (HOLD), driven straight from the state flop
//   m_ready       downstream accepts the result
//
// Build option: when HS_ARITH_STREAM_UMIN_TIE_LATEST_EN is defined, equal
// values replace the running minimum (ties select the latest beat) and the
// compare is done inline. When it is undefined, ties keep the earliest beat
// and the compare uses hs_arith_dual_in_uminimize.

package hs_arith_stream_uminimize_pkg;
  typedef enum logic {
    BOOL_FALSE = 1'b0,
    BOOL_TRUE  = 1'b1
  } bool_e;
endpackage

// Two-input unsigned minimum with per-input valid. dout_sel is 1 when din1
// is chosen. A strict less-than compare means ties keep din0. If only one
// input is valid, that input is chosen.
module hs_arith_dual_in_uminimize #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  din0_valid,
  input  logic [DATA_WIDTH-1:0] din1,
  input  logic                  din1_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_sel
);
  always_comb begin
    dout_sel = 1'b0;
    if (din1_valid && (!din0_valid || (din1 < din0))) dout_sel = 1'b1;
    dout = dout_sel ? din1 : din0;
  end
endmodule

module hs_arith_stream_uminimize
  import hs_arith_stream_uminimize_pkg::*;
#(
  parameter int    DATA_WIDTH      = 32,
  parameter int    IDX_WIDTH       = 8,
  parameter bool_e ENABLE_AUX_PATH = BOOL_TRUE,
  parameter type   AUX_DATA_TYPE   = logic
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  AUX_DATA_TYPE          s_aux,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_value,
  output AUX_DATA_TYPE          m_aux,
  output logic [IDX_WIDTH-1:0]  m_index,
  output logic [IDX_WIDTH-1:0]  m_count,
  output logic                  m_overflow,
  output logic                  m_valid,
  input  logic                  m_ready
);
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic [IDX_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [IDX_WIDTH-1:0] CNT_ONE = IDX_WIDTH'(1);

  state_e state_q, state_d;

  // Internal state exposed under a single name for checkers to bind to.
  state_e state_dbg;
  assign state_dbg = state_q;

  logic                  started_q;
  logic [IDX_WIDTH-1:0]  cnt_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [DATA_WIDTH-1:0] min_q;
  logic                  ovf_q;

  logic [DATA_WIDTH-1:0] m_value_q;
  logic [IDX_WIDTH-1:0]  m_index_q;
  logic [IDX_WIDTH-1:0]  m_count_q;
  logic                  m_overflow_q;

  logic                  accept;
  logic                  handshake;
  logic                  cnt_sat;
  logic [IDX_WIDTH-1:0]  cnt_nxt;
  logic                  ovf_nxt;
  logic                  replace;
  logic [DATA_WIDTH-1:0] min_nxt;
  logic [IDX_WIDTH-1:0]  idx_nxt;

  assign s_ready   = (state_q == ST_ACCUM);
  assign m_valid   = (state_q == ST_HOLD);
  assign accept    = s_valid && s_ready;
  assign handshake = m_valid && m_ready;

  // The first beat of a frame sits at position 0. Later beats advance the
  // counter until it saturates. A beat that arrives while the counter is
  // already saturated sets the sticky overflow flag.
  assign cnt_sat = (cnt_q == CNT_MAX);
  assign cnt_nxt = !started_q ? '0 : (cnt_sat ? cnt_q : cnt_q + CNT_ONE);
  assign ovf_nxt = ovf_q | (started_q & cnt_sat);

`ifdef HS_ARITH_STREAM_UMIN_TIE_LATEST_EN
  // Equal values also replace, so the latest of tied beats wins.
  assign replace = !started_q || (s_data <= min_q);
  assign min_nxt = replace ? s_data : min_q;
`else
  // Before the first beat of a frame the running min is not valid, so the
  // dual-input block always selects s_data on that beat.
  hs_arith_dual_in_uminimize #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .din0       (min_q),
    .din0_valid (started_q),
    .din1       (s_data),
    .din1_valid (1'b1),
    .dout       (min_nxt),
    .dout_sel   (replace)
  );
`endif

  assign idx_nxt = replace ? cnt_nxt : idx_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (accept && s_last) state_d = ST_HOLD;
      ST_HOLD:  if (m_ready)          state_d = ST_ACCUM;
      default:                        state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACCUM;
      started_q    <= 1'b0;
      cnt_q        <= '0;
      idx_q        <= '0;
      min_q        <= '0;
      ovf_q        <= 1'b0;
      m_value_q    <= '0;
      m_index_q    <= '0;
      m_count_q    <= '0;
      m_overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        started_q <= 1'b0;
        cnt_q     <= '0;
        ovf_q     <= 1'b0;
      end else if (accept) begin
        started_q <= 1'b1;
        cnt_q     <= cnt_nxt;
        idx_q     <= idx_nxt;
        min_q     <= min_nxt;
        ovf_q     <= ovf_nxt;
        // Results are captured from the next-state values so that the last
        // beat itself takes part in the minimum.
        if (s_last) begin
          m_value_q    <= min_nxt;
          m_index_q    <= idx_nxt;
          m_count_q    <= cnt_nxt;
          m_overflow_q <= ovf_nxt;
        end
      end
    end
  end

  assign m_value    = m_value_q;
  assign m_index    = m_index_q;
  assign m_count    = m_count_q;
  assign m_overflow = m_overflow_q;

  generate
    if (ENABLE_AUX_PATH == BOOL_TRUE) begin : g_aux
      AUX_DATA_TYPE aux_q;
      AUX_DATA_TYPE m_aux_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          aux_q   <= '0;
          m_aux_q <= '0;
        end else if (accept && !handshake) begin
          if (replace) aux_q <= s_aux;
          if (s_last) m_aux_q <= replace ? s_aux : aux_q;
        end
      end
      assign m_aux = m_aux_q;
    end else begin : g_no_aux
      assign m_aux = '0;
    end
  endgenerate

endmodule

// File: tb/tb_hs_arith_stream_uminimize.sv
// Bench for hs_arith_stream_uminimize. Two instances share one input stream:
// dut_a uses the default widths, and dut_b uses IDX_WIDTH=2 so that counter
// saturation and overflow are reached by short frames.
module tb_hs_arith_stream_uminimize;
  import hs_arith_stream_uminimize_pkg::*;

`ifdef HS_ARITH_STREAM_UMIN_TIE_LATEST_EN
  localparam bit TIE_LATEST = 1'b1;
`else
  localparam bit TIE_LATEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_aux = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;

  logic        s_ready_a, m_aux_a, m_overflow_a, m_valid_a;
  logic [31:0] m_value_a;
  logic [7:0]  m_index_a, m_count_a;

  logic        s_ready_b, m_aux_b, m_overflow_b, m_valid_b;
  logic [31:0] m_value_b;
  logic [1:0]  m_index_b, m_count_b;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] q_d[$];
  logic        q_a[$];

  always #5 clk = ~clk;

  hs_arith_stream_uminimize dut_a (
    .clk(clk), .rst(rst), .s_data(s_data), .s_aux(s_aux), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready_a), .m_value(m_value_a), .m_aux(m_aux_a),
    .m_index(m_index_a), .m_count(m_count_a), .m_overflow(m_overflow_a),
    .m_valid(m_valid_a), .m_ready(m_ready)
  );

  hs_arith_stream_uminimize #(.IDX_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data), .s_aux(s_aux), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready_b), .m_value(m_value_b), .m_aux(m_aux_b),
    .m_index(m_index_b), .m_count(m_count_b), .m_overflow(m_overflow_b),
    .m_valid(m_valid_b), .m_ready(m_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the minimum over the recorded frame, the first (or last,
  // with tie-latest) position holding it, and the counts clipped at max_idx.
  function automatic void model(input int max_idx, output logic [31:0] v,
                                output logic a, output int idx, output int cnt,
                                output logic ovf);
    int n;
    n = q_d.size();
    v = q_d[0];
    a = q_a[0];
    idx = 0;
    for (int i = 1; i < n; i++) begin
      if (q_d[i] < v || (TIE_LATEST && q_d[i] == v)) begin
        v = q_d[i];
        a = q_a[i];
        idx = i;
      end
    end
    if (idx > max_idx) idx = max_idx;
    cnt = (n - 1 > max_idx) ? max_idx : n - 1;
    ovf = (n - 1 > max_idx);
  endfunction

  task automatic check_frame(input string tag);
    logic [31:0] v;
    logic a, ovf;
    int idx, cnt;
    model(255, v, a, idx, cnt, ovf);
    chk({tag, "_a_value"}, m_value_a, v);
    chk({tag, "_a_aux"}, m_aux_a, a);
    chk({tag, "_a_index"}, m_index_a, idx);
    chk({tag, "_a_count"}, m_count_a, cnt);
    chk({tag, "_a_ovf"}, m_overflow_a, ovf);
    chk({tag, "_a_valid"}, m_valid_a, 1'b1);
    model(3, v, a, idx, cnt, ovf);
    chk({tag, "_b_value"}, m_value_b, v);
    chk({tag, "_b_aux"}, m_aux_b, a);
    chk({tag, "_b_index"}, m_index_b, idx);
    chk({tag, "_b_count"}, m_count_b, cnt);
    chk({tag, "_b_ovf"}, m_overflow_b, ovf);
    chk({tag, "_b_valid"}, m_valid_b, 1'b1);
  endtask

  // Called at #1 after a posedge, while in ACCUM.
  task automatic send(input logic [31:0] d, input logic last);
    logic a;
    a = 1'($urandom_range(0, 1));
    s_data = d;
    s_aux = a;
    s_valid = 1'b1;
    s_last = last;
    chk("s_ready_a_accum", s_ready_a, 1'b1);
    chk("s_ready_b_accum", s_ready_b, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last = 1'b0;
    q_d.push_back(d);
    q_a.push_back(a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // With m_ready=1 the result is taken at the next edge.
  task automatic finish_frame(input string tag);
    check_frame(tag);
    @(posedge clk); #1;
    chk({tag, "_a_released"}, m_valid_a, 1'b0);
    chk({tag, "_b_released"}, m_valid_b, 1'b0);
    chk({tag, "_a_ready_back"}, s_ready_a, 1'b1);
    q_d.delete();
    q_a.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, s_ready_a, 1'b1);
    chk({tag, "_m_valid_a"}, m_valid_a, 1'b0);
    chk({tag, "_m_valid_b"}, m_valid_b, 1'b0);
    chk({tag, "_m_value"}, m_value_a, 32'd0);
    chk({tag, "_m_aux"}, m_aux_a, 1'b0);
    chk({tag, "_m_index"}, m_index_a, 8'd0);
    chk({tag, "_m_count"}, m_count_a, 8'd0);
    chk({tag, "_m_overflow"}, m_overflow_a, 1'b0);
  endtask

  initial begin
    logic [31:0] hold_v;
    logic [7:0]  hold_i;
    int len, gap, stall;
    logic use_ties;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 40,7,19,7: ties keep the earlier 7 unless tie-latest is built in
    send(32'd40, 1'b0);
    send(32'd7, 1'b0);
    send(32'd19, 1'b0);
    send(32'd7, 1'b1);
    chk("f1_value", m_value_a, 32'd7);
    chk("f1_index", m_index_a, TIE_LATEST ? 8'd3 : 8'd1);
    chk("f1_count", m_count_a, 8'd3);
    chk("f1_valid", m_valid_a, 1'b1);
    finish_frame("f1");

    // Single all-ones beat
    send(32'hFFFF_FFFF, 1'b1);
    chk("single_value", m_value_a, 32'hFFFF_FFFF);
    chk("single_index", m_index_a, 8'd0);
    chk("single_count", m_count_a, 8'd0);
    chk("single_ovf", m_overflow_a, 1'b0);
    finish_frame("single");

    // Downstream stall with s_valid held high
    m_ready = 1'b0;
    send(32'd12, 1'b0);
    send(32'd30, 1'b1);
    hold_v = m_value_a;
    hold_i = m_index_a;
    check_frame("stall0");
    for (int i = 0; i < 5; i++) begin
      s_data = $urandom;
      s_valid = 1'b1;
      @(posedge clk); #1;
      chk("stall_s_ready", s_ready_a, 1'b0);
      chk("stall_value_stable", m_value_a, hold_v);
      chk("stall_index_stable", m_index_a, hold_i);
      check_frame("stall");
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", m_valid_a, 1'b0);
    chk("stall_release_ready", s_ready_a, 1'b1);
    q_d.delete();
    q_a.delete();

    // Overflow on the IDX_WIDTH=2 instance
    send(32'd9, 1'b0);
    send(32'd8, 1'b0);
    send(32'd7, 1'b0);
    send(32'd6, 1'b0);
    send(32'd5, 1'b0);
    send(32'd4, 1'b1);
    chk("ovf_b_count", m_count_b, 2'd3);
    chk("ovf_b_flag", m_overflow_b, 1'b1);
    chk("ovf_b_value", m_value_b, 32'd4);
    chk("ovf_b_index", m_index_b, 2'd3);
    chk("ovf_a_index", m_index_a, 8'd5);
    finish_frame("ovf");

    // Reset in the middle of a frame
    send(32'd3, 1'b0);
    send(32'd1, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    chk("midreset_held_valid", m_valid_a, 1'b0);
    rst = 1'b0;
    q_d.delete();
    q_a.delete();
    @(posedge clk); #1;
    send(32'd5, 1'b1);
    chk("after_reset_value", m_value_a, 32'd5);
    chk("after_reset_index", m_index_a, 8'd0);
    finish_frame("after_reset");

    // Gaps inside a frame
    send(32'd4, 1'b0);
    idle($urandom_range(1, 3));
    send(32'd2, 1'b0);
    idle($urandom_range(1, 3));
    send(32'd6, 1'b1);
    chk("gap_value", m_value_a, 32'd2);
    chk("gap_index", m_index_a, 8'd1);
    chk("gap_count", m_count_a, 8'd2);
    finish_frame("gap");

    // Randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 9);
      use_ties = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
        if (b == len - 1) begin
          stall = $urandom_range(0, 2);
          m_ready = (stall == 0);
        end
        send(use_ties ? 32'($urandom_range(0, 3)) : $urandom, b == len - 1);
      end
      if (stall > 0) begin
        for (int i = 0; i < stall; i++) begin
          check_frame("rnd_stall");
          @(posedge clk); #1;
        end
        m_ready = 1'b1;
      end
      finish_frame("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_arith_stream_uminimize.md
HS_ARITH_STREAM_UMINIMIZE -- requirements
Module: hs_arith_stream_uminimize

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 32 and SHALL set the compared value width, range 1-128.
REQ-002 The parameter IDX_WIDTH SHALL default to 8 and SHALL set the beat-index and beat-count width, range 1-16.
REQ-003 The parameter ENABLE_AUX_PATH SHALL be of type bool_e, default BOOL_TRUE, and SHALL enable the auxiliary data path.
REQ-004 The parameter AUX_DATA_TYPE SHALL be a type, default logic, and SHALL be the auxiliary payload type.
REQ-005 The module SHALL have one clock, clk, and reset SHALL be asynchronous and active-high, named rst.
REQ-006 The ports SHALL be as follows, clock and reset first:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- s_data  in  DATA_WIDTH  input value, unsigned.
- s_aux  in  AUX_DATA_TYPE  input auxiliary payload.
- s_valid  in  1  input beat valid.
- s_last  in  1  marks the final beat of the frame.
- s_ready  out  1  block can accept an input beat.
- m_value  out  DATA_WIDTH  frame minimum.
- m_aux  out  AUX_DATA_TYPE  auxiliary payload of the minimum beat.
- m_index  out  IDX_WIDTH  beat position of the minimum, zero-based.
- m_count  out  IDX_WIDTH  accepted beats minus 1.
- m_overflow  out  1  frame exceeded 2^IDX_WIDTH beats.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.

Function
REQ-007 The block SHALL use a two-state FSM: ACCUM, then HOLD.
REQ-008 In ACCUM, s_ready SHALL be 1 and m_valid SHALL be 0.
REQ-009 In HOLD, s_ready SHALL be 0 and m_valid SHALL be 1.
REQ-010 An input beat SHALL be accepted when s_valid && s_ready at a rising clock edge.
REQ-011 On the first accepted beat of a frame, the running min SHALL load s_data/s_aux, the min index SHALL be 0 and the beat counter SHALL be 0.
REQ-012 Each later accepted beat SHALL increment the beat counter.
REQ-013 The running min SHALL be replaced when s_data < running min, so ties keep the earlier beat.
REQ-014 On replacement, the min index SHALL be set to the post-increment counter value.
REQ-015 The comparison SHALL instantiate hs_arith_dual_in_uminimize with din0 = running min, din0_valid = frame-started flag, din1 = s_data, din1_valid = 1.
REQ-016 The beat counter SHALL saturate at 2^IDX_WIDTH-1.
REQ-017 A beat accepted while the counter is saturated SHALL set sticky overflow and SHALL still be compared, with the min index set to the saturated value.
REQ-018 An accepted beat with s_last=1 SHALL cause a transition to HOLD at the same edge, with all m_* results registered at that edge; m_valid SHALL rise in the following cycle (latency 1 cycle from last-beat acceptance).
REQ-019 A single-beat frame SHALL produce m_index=0 and m_count=0.
REQ-020 In HOLD, m_value, m_aux, m_index, m_count and m_overflow SHALL stay stable until m_valid && m_ready.
REQ-021 On the handshake m_valid && m_ready, the FSM SHALL return to ACCUM and the frame-started flag, counter and overflow SHALL clear.
REQ-022 The first beat of the next frame SHALL be accepted no earlier than the cycle after the handshake (no same-cycle pass-through).
REQ-023 s_valid=0 cycles within a frame SHALL leave all state unchanged.
REQ-024 When ENABLE_AUX_PATH=BOOL_FALSE, m_aux SHALL be constant '0 and s_aux SHALL be ignored.
REQ-025 m_valid SHALL be registered, with no combinational path from s_* to m_valid.

Reset
REQ-026 While rst=1, the FSM SHALL be ACCUM, s_ready=1, m_valid=0, m_value='0, m_aux='0, m_index=0, m_count=0, m_overflow=0, and the frame-started flag SHALL be 0.
REQ-027 Reset asserted mid-frame or in HOLD SHALL discard the partial or unconsumed result immediately and asynchronously.
REQ-028 After reset release, the next accepted beat SHALL be treated as the first beat of a new frame.

Configuration
REQ-029 When macro HS_ARITH_STREAM_UMIN_TIE_LATEST_EN is defined, replacement SHALL occur when s_data <= running min, so ties select the latest beat.
REQ-030 In that mode, the first-beat load and all other behaviour SHALL be unchanged, and the dual-input instance SHALL be replaced by an inline <= compare.
REQ-031 When HS_ARITH_STREAM_UMIN_TIE_LATEST_EN is undefined, REQ-013 SHALL apply, so ties select the earliest beat.

Verification
REQ-032 The bench SHALL drive the frame 40,7,19,7(last) with m_ready=1 and SHALL check, one cycle after the last beat: m_value=7, m_index=1, m_count=3, m_valid=1. With the macro defined, m_index SHALL be 3.
REQ-033 The bench SHALL drive a single beat 0xFFFFFFFF with s_last=1 and SHALL check m_value=0xFFFFFFFF, m_index=0, m_count=0, m_overflow=0.
REQ-034 The bench SHALL hold m_ready=0 for 5 cycles after the result while s_valid=1, and SHALL check that s_ready=0 throughout and outputs stay stable; on m_ready=1, the FSM SHALL return to ACCUM the next cycle.
REQ-035 With IDX_WIDTH=2, the bench SHALL drive 6 beats 9,8,7,6,5,4(last) and SHALL check m_count=3, m_overflow=1, m_value=4, m_index=3.
REQ-036 The bench SHALL assert rst after 2 beats of the frame 3,1 and SHALL then send the frame 5(last), checking m_value=5, m_index=0 and m_valid=0 during reset.
REQ-037 The bench SHALL insert s_valid gaps of 1-3 cycles in the frame 4,2,6(last) and SHALL check m_value=2, m_index=1, m_count=2.
